pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Each cycle it decides whether the PC, IF/ID and ID/EX registers advance, hold or are flushed, covering three cases: load-use hazards, taken jumps/branches resolved in EX, and multi-cycle EX operations such as the divider. It sits beside the ID/EX register and drives that register's hold/flush inputs, plus those of the PC and IF/ID register. It also keeps saturating stall/flush counters and a sticky multi-cycle timeout flag for debug.

## Interface
- CNT_W, 32, width of the stall and flush performance counters
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before a forced release (≥2)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- id_rs1_raddr_i  input  5  rs1 address of the instruction in ID
- id_rs1_re_i  input  1  ID instruction reads rs1
- id_rs2_raddr_i  input  5  rs2 address of the instruction in ID
- id_rs2_re_i  input  1  ID instruction reads rs2
- id_ex_reg_waddr_i  input  5  destination of the instruction in EX (ID/EX register output)
- id_ex_reg_we_i  input  1  EX instruction writes the register file
- id_ex_is_load_i  input  1  EX instruction is a load
- ex_jump_i  input  1  EX resolved a taken branch or jump this cycle
- ex_mc_start_i  input  1  EX holds a multi-cycle op
- ex_mc_done_i  input  1  multi-cycle unit result valid this cycle
- ctrl_clr_i  input  1  synchronous clear of counters and timeout flag
- ctrl_pc_hold_o  output  1  PC keeps its value
- ctrl_if_id_hold_o  output  1  IF/ID keeps its value
- ctrl_if_id_flush_o  output  1  IF/ID loads a NOP
- ctrl_id_ex_hold_o  output  1  ID/EX keeps its value
- ctrl_id_ex_flush_o  output  1  ID/EX loads a bubble (we=0, ALUctrl=NO_OP, waddr=0)
- ctrl_state_o  output  2  current FSM state (RUN=0, MC_WAIT=1)
- ctrl_stall_cnt_o  output  CNT_W  cycles with any hold asserted
- ctrl_flush_cnt_o  output  CNT_W  cycles with any flush asserted
- ctrl_mc_timeout_o  output  1  sticky: an MC_WAIT was force-released

## Operation
- The FSM state is registered. Hold/flush outputs are combinational from the state and the current inputs, so they act on the same clock edge.
- Load-use hazard (lu): id_ex_is_load_i & id_ex_reg_we_i & (id_ex_reg_waddr_i≠0) & ((id_rs1_re_i & rs1==waddr) | (id_rs2_re_i & rs2==waddr)).
- RUN, priority order:
  1. ex_jump_i: if_id_flush=1, id_ex_flush=1, no holds. Stay in RUN. ex_mc_start_i and lu are ignored.
  2. ex_mc_start_i & !ex_mc_done_i: pc_hold=if_id_hold=id_ex_hold=1. Go to MC_WAIT and clear the timer.
  3. ex_mc_start_i & ex_mc_done_i: op completes in one cycle, no action.
  4. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1 (one bubble). Stay in RUN.
  5. Otherwise all outputs are 0.
- MC_WAIT:
  - pc_hold=if_id_hold=id_ex_hold=1 every cycle in which release does not occur.
  - ex_jump_i and lu are ignored.
  - Release on ex_mc_done_i, or on timer==MC_TIMEOUT-1. In the release cycle all holds are 0, the pipeline advances, and the FSM goes to RUN.
  - A release caused by the timer without done sets ctrl_mc_timeout_o.
  - Otherwise the timer increments.
- Timer width is clog2(MC_TIMEOUT). The timer is 0 on the first MC_WAIT cycle, so at most MC_TIMEOUT cycles are spent in MC_WAIT.
- Counters:
  - stall_cnt increments in every cycle with any *_hold_o=1.
  - flush_cnt increments in every cycle with any *_flush_o=1.
  - Both saturate at 2^CNT_W-1.
  - ctrl_clr_i zeroes both counters and the timeout flag and overrides any increment that cycle. It does not affect the FSM.
- Hold and flush are never asserted together on the same register.

## Timing
- Reset values: state=RUN, timer=0, counters=0, ctrl_mc_timeout_o=0, ctrl_state_o=0. Hold/flush outputs are 0 unless inputs assert a RUN case.
- Reset asserted in MC_WAIT returns the FSM to RUN immediately. The timeout flag is not set.
- Load-use costs exactly 1 bubble cycle. The next cycle the load is in MEM, lu deasserts and forwarding resolves the dependency.
- Jump penalty is 2 instructions, both flushed in the same cycle.
- A multi-cycle op whose done arrives N cycles after start (N≥1) stalls for N cycles. The pipeline advances on the edge ending the done cycle.
- Counter and flag updates appear one cycle after the qualifying cycle.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with re=1 -> one cycle of pc_hold=if_id_hold=id_ex_flush=1, then 0. stall_cnt=1, flush_cnt=1. Same case with waddr=0 or re=0 -> no action.
- ex_jump_i=1 in RUN with lu also true -> if_id_flush=id_ex_flush=1, no holds. flush_cnt+1.
- ex_mc_start_i at cycle 0, done at cycle 5 -> holds asserted in cycles 0–4 and 0 in cycle 5. State 0→1→0. stall_cnt=5.
- ex_mc_start_i and ex_mc_done_i in the same cycle -> no holds, state stays RUN.
- MC_TIMEOUT=4, start with no done -> holds for 4 cycles (0–3). Release in MC_WAIT cycle 4 (timer=3). ctrl_mc_timeout_o=1 until ctrl_clr_i, which also zeroes the counters.
- CNT_W=4, hold for 20 cycles -> stall_cnt saturates at 15. rst_n pulse mid-MC_WAIT -> state 0 and all counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hold/flush sequencing for the 5-stage core
//
// Decides every cycle whether PC, IF/ID and ID/EX advance, hold or flush.
// Handles load-use hazards, taken jumps resolved in EX and multi-cycle EX ops.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   id_rs1_*/id_rs2_*        source operands of the instruction in ID
//   id_ex_reg_*/id_ex_is_load_i  destination info of the instruction in EX
//   ex_jump_i                taken branch/jump resolved in EX this cycle
//   ex_mc_start_i/_done_i    multi-cycle op present in EX / result valid
//   ctrl_clr_i               synchronous clear of debug counters and flag
//   ctrl_*_hold_o/_flush_o   combinational hold/flush controls
//   ctrl_state_o             FSM state (RUN=0, MC_WAIT=1)
//   ctrl_stall_cnt_o         saturating count of cycles with any hold
//   ctrl_flush_cnt_o         saturating count of cycles with any flush
//   ctrl_mc_timeout_o        sticky: an MC_WAIT ended by timer, not done

module pipe_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_raddr_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_raddr_i,
  input  logic             id_rs2_re_i,
  input  logic [4:0]       id_ex_reg_waddr_i,
  input  logic             id_ex_reg_we_i,
  input  logic             id_ex_is_load_i,
  input  logic             ex_jump_i,
  input  logic             ex_mc_start_i,
  input  logic             ex_mc_done_i,
  input  logic             ctrl_clr_i,
  output logic             ctrl_pc_hold_o,
  output logic             ctrl_if_id_hold_o,
  output logic             ctrl_if_id_flush_o,
  output logic             ctrl_id_ex_hold_o,
  output logic             ctrl_id_ex_flush_o,
  output logic [1:0]       ctrl_state_o,
  output logic [CNT_W-1:0] ctrl_stall_cnt_o,
  output logic [CNT_W-1:0] ctrl_flush_cnt_o,
  output logic             ctrl_mc_timeout_o
);

  localparam int TMR_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mc_timeout_q, mc_timeout_d;

  logic load_use;
  logic timeout_set;
  logic any_hold;
  logic any_flush;

  // The x0 guard matters: a load to x0 never produces a value to wait for.
  assign load_use = id_ex_is_load_i & id_ex_reg_we_i & (id_ex_reg_waddr_i != 5'd0) &
                    ((id_rs1_re_i & (id_rs1_raddr_i == id_ex_reg_waddr_i)) |
                     (id_rs2_re_i & (id_rs2_raddr_i == id_ex_reg_waddr_i)));

  always_comb begin
    state_d            = state_q;
    timer_d            = timer_q;
    timeout_set        = 1'b0;
    ctrl_pc_hold_o     = 1'b0;
    ctrl_if_id_hold_o  = 1'b0;
    ctrl_if_id_flush_o = 1'b0;
    ctrl_id_ex_hold_o  = 1'b0;
    ctrl_id_ex_flush_o = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_jump_i) begin
          // Both younger instructions are on the wrong path.
          ctrl_if_id_flush_o = 1'b1;
          ctrl_id_ex_flush_o = 1'b1;
        end else if (ex_mc_start_i && !ex_mc_done_i) begin
          ctrl_pc_hold_o    = 1'b1;
          ctrl_if_id_hold_o = 1'b1;
          ctrl_id_ex_hold_o = 1'b1;
          state_d           = ST_MC_WAIT;
          timer_d           = '0;
        end else if (ex_mc_start_i && ex_mc_done_i) begin
          // Single-cycle completion: nothing to do.
        end else if (load_use) begin
          // Freeze fetch/decode and insert one bubble into EX.
          ctrl_pc_hold_o     = 1'b1;
          ctrl_if_id_hold_o  = 1'b1;
          ctrl_id_ex_flush_o = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (ex_mc_done_i || (timer_q == TMR_LAST)) begin
          state_d     = ST_RUN;
          timeout_set = ~ex_mc_done_i;
        end else begin
          ctrl_pc_hold_o    = 1'b1;
          ctrl_if_id_hold_o = 1'b1;
          ctrl_id_ex_hold_o = 1'b1;
          timer_d           = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  assign any_hold  = ctrl_pc_hold_o | ctrl_if_id_hold_o | ctrl_id_ex_hold_o;
  assign any_flush = ctrl_if_id_flush_o | ctrl_id_ex_flush_o;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    mc_timeout_d = mc_timeout_q | timeout_set;
    if (any_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (any_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    // Clear wins over any increment or flag set in the same cycle.
    if (ctrl_clr_i) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      mc_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign ctrl_state_o      = state_q;
  assign ctrl_stall_cnt_o  = stall_cnt_q;
  assign ctrl_flush_cnt_o  = flush_cnt_q;
  assign ctrl_mc_timeout_o = mc_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
//
// Two instances share one stimulus stream: "a" uses CNT_W=32/MC_TIMEOUT=64,
// "b" uses CNT_W=4/MC_TIMEOUT=4 so saturation and timeout are reachable.

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, waddr;
  logic       re1, re2, we, is_load, jump, start, done, clr;

  logic        a_pc_h, a_ifid_h, a_ifid_f, a_idex_h, a_idex_f, a_to;
  logic [1:0]  a_st;
  logic [31:0] a_sc, a_fc;
  logic        b_pc_h, b_ifid_h, b_ifid_f, b_idex_h, b_idex_f, b_to;
  logic [1:0]  b_st;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32), .MC_TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_raddr_i(rs1), .id_rs1_re_i(re1), .id_rs2_raddr_i(rs2), .id_rs2_re_i(re2),
    .id_ex_reg_waddr_i(waddr), .id_ex_reg_we_i(we), .id_ex_is_load_i(is_load),
    .ex_jump_i(jump), .ex_mc_start_i(start), .ex_mc_done_i(done), .ctrl_clr_i(clr),
    .ctrl_pc_hold_o(a_pc_h), .ctrl_if_id_hold_o(a_ifid_h), .ctrl_if_id_flush_o(a_ifid_f),
    .ctrl_id_ex_hold_o(a_idex_h), .ctrl_id_ex_flush_o(a_idex_f), .ctrl_state_o(a_st),
    .ctrl_stall_cnt_o(a_sc), .ctrl_flush_cnt_o(a_fc), .ctrl_mc_timeout_o(a_to)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .MC_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_raddr_i(rs1), .id_rs1_re_i(re1), .id_rs2_raddr_i(rs2), .id_rs2_re_i(re2),
    .id_ex_reg_waddr_i(waddr), .id_ex_reg_we_i(we), .id_ex_is_load_i(is_load),
    .ex_jump_i(jump), .ex_mc_start_i(start), .ex_mc_done_i(done), .ctrl_clr_i(clr),
    .ctrl_pc_hold_o(b_pc_h), .ctrl_if_id_hold_o(b_ifid_h), .ctrl_if_id_flush_o(b_ifid_f),
    .ctrl_id_ex_hold_o(b_idex_h), .ctrl_id_ex_flush_o(b_idex_f), .ctrl_state_o(b_st),
    .ctrl_stall_cnt_o(b_sc), .ctrl_flush_cnt_o(b_fc), .ctrl_mc_timeout_o(b_to)
  );

  // Hold/flush vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush}
  logic [4:0] a_hf, b_hf;
  assign a_hf = {a_pc_h, a_ifid_h, a_ifid_f, a_idex_h, a_idex_f};
  assign b_hf = {b_pc_h, b_ifid_h, b_ifid_f, b_idex_h, b_idex_f};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     lim [2]  = '{64, 4};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  bit     m_wait [2];
  int     m_el [2];     // cycles already spent waiting in the current MC wait
  longint m_sc [2];
  longint m_fc [2];
  bit     m_to [2];

  function automatic bit lu_now();
    return is_load && we && (waddr != 0) &&
           ((re1 && rs1 == waddr) || (re2 && rs2 == waddr));
  endfunction

  function automatic logic [4:0] model_hf(input int i);
    if (m_wait[i]) begin
      if (done || m_el[i] == lim[i] - 1) return 5'b00000;
      return 5'b11010;
    end
    if (jump) return 5'b00101;
    if (start && !done) return 5'b11010;
    if (start && done) return 5'b00000;
    if (lu_now()) return 5'b11001;
    return 5'b00000;
  endfunction

  logic [4:0] mh;
  bit         to_set;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_wait[i] <= 1'b0; m_el[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0; m_to[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mh = model_hf(i);
        to_set = 1'b0;
        if (m_wait[i]) begin
          if (done || m_el[i] == lim[i] - 1) begin
            m_wait[i] <= 1'b0;
            to_set = !done;
          end else begin
            m_el[i] <= m_el[i] + 1;
          end
        end else if (!jump && start && !done) begin
          m_wait[i] <= 1'b1;
          m_el[i]   <= 0;
        end
        if (clr) begin
          m_sc[i] <= 0; m_fc[i] <= 0; m_to[i] <= 1'b0;
        end else begin
          if ((mh[4] || mh[3] || mh[1]) && m_sc[i] < cmax[i]) m_sc[i] <= m_sc[i] + 1;
          if ((mh[2] || mh[0]) && m_fc[i] < cmax[i]) m_fc[i] <= m_fc[i] + 1;
          if (to_set) m_to[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_hf",    a_hf,  model_hf(0));
    chk("a_state", a_st,  m_wait[0] ? 1 : 0);
    chk("a_stall", a_sc,  m_sc[0]);
    chk("a_flush", a_fc,  m_fc[0]);
    chk("a_to",    a_to,  m_to[0]);
    chk("b_hf",    b_hf,  model_hf(1));
    chk("b_state", b_st,  m_wait[1] ? 1 : 0);
    chk("b_stall", b_sc,  m_sc[1]);
    chk("b_flush", b_fc,  m_fc[1]);
    chk("b_to",    b_to,  m_to[1]);
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input bit j, input bit s, input bit d, input bit ld, input bit w,
                        input logic [4:0] wa, input logic [4:0] r1, input bit e1,
                        input logic [4:0] r2, input bit e2, input bit c);
    jump = j; start = s; done = d; is_load = ld; we = w; waddr = wa;
    rs1 = r1; re1 = e1; rs2 = r2; re2 = e2; clr = c;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_a_state", a_st, 0);
    chk("rst_a_stall", a_sc, 0);
    chk("rst_b_to",    b_to, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load x5 in EX, ID reads rs2=x5
    set_in(0, 0, 0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0);
    @(negedge clk); chk("lu_hf", a_hf, 5'b11001); next();
    idle();
    @(negedge clk); chk("lu_after_hf", a_hf, 0);
    chk("lu_stall_cnt", a_sc, 1); chk("lu_flush_cnt", a_fc, 1); next();
    set_in(0, 0, 0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0);
    @(negedge clk); chk("lu_x0_hf", a_hf, 0); next();
    set_in(0, 0, 0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 0, 0);
    @(negedge clk); chk("lu_re0_hf", a_hf, 0); next();
    set_in(0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd0, 0, 0);
    @(negedge clk); chk("alu_dep_hf", a_hf, 0); next();
    set_in(0, 0, 0, 1, 1, 5'd7, 5'd7, 1, 5'd0, 0, 0);
    @(negedge clk); chk("lu_rs1_hf", a_hf, 5'b11001); next();
    idle();
    @(negedge clk); chk("lu2_stall_cnt", a_sc, 2); chk("lu2_flush_cnt", a_fc, 2); next();
    do_clr();
    idle();
    @(negedge clk); chk("clr_stall_cnt", a_sc, 0); chk("clr_flush_cnt", a_fc, 0); next();

    // Jump beats load-use and mc start
    set_in(1, 1, 0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0);
    @(negedge clk); chk("jump_hf", a_hf, 5'b00101); chk("jump_b_hf", b_hf, 5'b00101); next();
    idle();
    @(negedge clk); chk("jump_flush_cnt", a_fc, 1); chk("jump_stall_cnt", a_sc, 0);
    chk("jump_state", a_st, 0); next();

    // Start and done together
    set_in(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk); chk("mc1_hf", a_hf, 0); next();
    idle();
    @(negedge clk); chk("mc1_state", a_st, 0); next();

    // Multi-cycle op, done in cycle 5
    do_clr();
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk); chk("mc_c0_hf", a_hf, 5'b11010); chk("mc_c0_state", a_st, 0); next();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); chk("mc_wait_hf", a_hf, 5'b11010); chk("mc_wait_state", a_st, 1); next();
    end
    set_in(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk); chk("mc_done_hf", a_hf, 0); chk("mc_done_state", a_st, 1); next();
    idle();
    @(negedge clk); chk("mc_end_state", a_st, 0); chk("mc_stall_cnt", a_sc, 5); next();

    // Timeout on instance b (MC_TIMEOUT=4)
    do_clr();
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk); chk("to_c0_hf", b_hf, 5'b11010); next();
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); chk("to_wait_hf", b_hf, 5'b11010); chk("to_wait_state", b_st, 1); next();
    end
    @(negedge clk); chk("to_rel_hf", b_hf, 0); chk("to_rel_state", b_st, 1);
    chk("to_rel_flag", b_to, 0); next();
    @(negedge clk); chk("to_flag", b_to, 1); chk("to_b_state", b_st, 0);
    chk("to_b_stall", b_sc, 4); chk("to_a_state", a_st, 1); next();
    set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk); chk("to_a_rel_hf", a_hf, 0); next();
    idle();
    @(negedge clk); chk("to_a_end_state", a_st, 0); chk("to_flag_sticky", b_to, 1); next();
    set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    @(negedge clk); chk("to_flag_in_clr", b_to, 1); next();
    idle();
    @(negedge clk); chk("to_flag_clr", b_to, 0); chk("clr_b_stall", b_sc, 0);
    chk("clr_b_flush", b_fc, 0); next();

    // Saturation: 20 consecutive load-use cycles
    for (int k = 0; k < 20; k++) begin
      set_in(0, 0, 0, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0);
      next();
    end
    idle();
    @(negedge clk); chk("sat_b_stall", b_sc, 15); chk("sat_b_flush", b_fc, 15);
    chk("sat_a_stall", a_sc, 20); next();

    // Reset mid MC_WAIT
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    next();
    idle();
    @(negedge clk); chk("pre_rst_state", b_st, 1); next();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a_state", a_st, 0); chk("rst_mid_b_state", b_st, 0);
    chk("rst_mid_a_stall", a_sc, 0); chk("rst_mid_a_flush", a_fc, 0);
    chk("rst_mid_b_to", b_to, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("post_rst_state", a_st, 0); next();
    repeat (2) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
